// File: rtl/param_datacache_if.sv
// Bundles the core load/store port and the backing-memory word port of
// param_datacache.
//   slave  : cache side. Takes the core request and the memory response, and
//            drives the load result and the memory request.
//   master : environment side (core plus memory), with the directions reversed.
// Core port   : in (word address), readable, writable, write (store data),
//               out (load data or echoed store data), over (completion pulse).
// Memory port : mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ack.
interface param_datacache_if #(
  parameter int WORD_SIZE = 32
);
  logic [WORD_SIZE-1:0] in;
  logic                 readable;
  logic                 writable;
  logic [WORD_SIZE-1:0] write;
  logic [WORD_SIZE-1:0] out;
  logic                 over;
  logic                 mem_req;
  logic                 mem_we;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] mem_rdata;
  logic                 mem_ack;

  modport slave (
    input  in, readable, writable, write, mem_rdata, mem_ack,
    output out, over, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in, readable, writable, write, mem_rdata, mem_ack,
    input  out, over, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/param_datacache.sv
// Direct-mapped data cache that sits between the core load/store port and a
// word-wide backing memory. Word width, set count and line length are
// parameters. WRITE_BACK selects the write policy: 1 gives write-back with
// write-allocate, 0 gives write-through with no allocate.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous reset, active low
//   bus   : param_datacache_if.slave. Carries the core request, out/over, and
//           the req/ack memory handshake. Each memory word is one transaction,
//           and mem_req drops for at least one cycle between words.
module param_datacache #(
  parameter int WORD_SIZE   = 32,
  parameter int INDEX_BITS  = 4,
  parameter int OFFSET_BITS = 2,
  parameter bit WRITE_BACK  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  param_datacache_if.slave    bus
);
  localparam int TAG_W      = WORD_SIZE - INDEX_BITS - OFFSET_BITS;
  localparam int LINES      = 1 << INDEX_BITS;
  localparam int LINE_WORDS = 1 << OFFSET_BITS;
  localparam int AW         = INDEX_BITS + OFFSET_BITS;

  typedef enum logic [2:0] {IDLE, LOOKUP, WBACK, REFILL, WTHRU, DONE} state_t;

  state_t                   state_q, state_d;
  logic [WORD_SIZE-1:0]     addr_q, addr_d;
  logic [WORD_SIZE-1:0]     wdata_q, wdata_d;
  logic                     is_wr_q, is_wr_d;
  logic [WORD_SIZE-1:0]     out_q, out_d;
  logic                     over_q, over_d;
  logic [WORD_SIZE-1:0]     fill_q, fill_d;
  logic [OFFSET_BITS-1:0]   cnt_q, cnt_d;
  logic                     mreq_q, mreq_d;
  logic                     mwe_q, mwe_d;
  logic [WORD_SIZE-1:0]     maddr_q, maddr_d;
  logic [WORD_SIZE-1:0]     mwdata_q, mwdata_d;
  logic [LINES-1:0]         valid_q, valid_d;
  logic [LINES-1:0]         dirty_q, dirty_d;

  // Tag and data storage are not reset. The valid bits alone decide hits.
  logic [TAG_W-1:0]         tag_mem  [LINES];
  logic [WORD_SIZE-1:0]     data_mem [LINES*LINE_WORDS];
  logic                     tag_we;
  logic                     data_we;
  logic [AW-1:0]            data_waddr;
  logic [WORD_SIZE-1:0]     data_wval;

  logic [TAG_W-1:0]         req_tag;
  logic [INDEX_BITS-1:0]    req_idx;
  logic [OFFSET_BITS-1:0]   req_off;
  logic                     hit;
  logic                     last_word;
  logic                     word_ack;

  assign req_tag   = addr_q[WORD_SIZE-1 -: TAG_W];
  assign req_idx   = addr_q[OFFSET_BITS +: INDEX_BITS];
  assign req_off   = addr_q[OFFSET_BITS-1:0];
  assign hit       = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign last_word = &cnt_q;
  assign word_ack  = mreq_q && bus.mem_ack;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_wr_d    = is_wr_q;
    out_d      = out_q;
    over_d     = 1'b0;
    fill_d     = fill_q;
    cnt_d      = cnt_q;
    mreq_d     = mreq_q;
    mwe_d      = mwe_q;
    maddr_d    = maddr_q;
    mwdata_d   = mwdata_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    tag_we     = 1'b0;
    data_we    = 1'b0;
    data_waddr = {req_idx, req_off};
    data_wval  = wdata_q;

    case (state_q)
      IDLE: begin
        if (bus.readable || bus.writable) begin
          addr_d  = bus.in;
          wdata_d = bus.write;
          is_wr_d = bus.writable;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit && !is_wr_q) begin
          out_d   = data_mem[{req_idx, req_off}];
          over_d  = 1'b1;
          state_d = DONE;
        end else if (hit) begin
          data_we = 1'b1;
          if (WRITE_BACK) begin
            dirty_d[req_idx] = 1'b1;
            out_d            = wdata_q;
            over_d           = 1'b1;
            state_d          = DONE;
          end else begin
            state_d = WTHRU;
          end
        end else if (is_wr_q && !WRITE_BACK) begin
          state_d = WTHRU;
        end else begin
          cnt_d   = '0;
          state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? WBACK : REFILL;
        end
      end
      WBACK: begin
        if (!mreq_q) begin
          mreq_d   = 1'b1;
          mwe_d    = 1'b1;
          maddr_d  = {tag_mem[req_idx], req_idx, cnt_q};
          mwdata_d = data_mem[{req_idx, cnt_q}];
        end else if (word_ack) begin
          mreq_d = 1'b0;
          cnt_d  = cnt_q + 1'b1;
          if (last_word) state_d = REFILL;
        end
      end
      REFILL: begin
        if (!mreq_q) begin
          mreq_d  = 1'b1;
          mwe_d   = 1'b0;
          maddr_d = {req_tag, req_idx, cnt_q};
        end else if (word_ack) begin
          mreq_d     = 1'b0;
          cnt_d      = cnt_q + 1'b1;
          data_we    = 1'b1;
          data_waddr = {req_idx, cnt_q};
          // A pending store overrides its own word as it arrives, so the
          // array needs only one write port.
          data_wval  = (is_wr_q && cnt_q == req_off) ? wdata_q : bus.mem_rdata;
          if (cnt_q == req_off) fill_d = bus.mem_rdata;
          if (last_word) begin
            valid_d[req_idx] = 1'b1;
            dirty_d[req_idx] = is_wr_q && WRITE_BACK;
            tag_we           = 1'b1;
            if (is_wr_q)                out_d = wdata_q;
            else if (cnt_q == req_off)  out_d = bus.mem_rdata;
            else                        out_d = fill_q;
            over_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      WTHRU: begin
        if (!mreq_q) begin
          mreq_d   = 1'b1;
          mwe_d    = 1'b1;
          maddr_d  = addr_q;
          mwdata_d = wdata_q;
        end else if (word_ack) begin
          mreq_d  = 1'b0;
          out_d   = wdata_q;
          over_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      is_wr_q  <= 1'b0;
      out_q    <= '0;
      over_q   <= 1'b0;
      fill_q   <= '0;
      cnt_q    <= '0;
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      valid_q  <= '0;
      dirty_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      is_wr_q  <= is_wr_d;
      out_q    <= out_d;
      over_q   <= over_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
      mreq_q   <= mreq_d;
      mwe_q    <= mwe_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      valid_q  <= valid_d;
      dirty_q  <= dirty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) data_mem[data_waddr] <= data_wval;
    if (tag_we)  tag_mem[req_idx]     <= req_tag;
  end

  assign bus.out       = out_q;
  assign bus.over      = over_q;
  assign bus.mem_req   = mreq_q;
  assign bus.mem_we    = mwe_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = mwdata_q;
endmodule

// File: tb/tb_param_datacache.sv
// Bench for param_datacache. It runs a write-back instance (index 0) and a
// write-through instance (index 1) side by side. Each instance has its own
// backing memory responder. The bench also keeps a cache model: resident lines
// plus its own copy of memory, from which it predicts the memory transactions
// and load results of every access.
module tb_param_datacache;
  logic clk = 1'b0;
  logic rst_n;
  initial forever #5 clk = ~clk;

  param_datacache_if #(.WORD_SIZE(32)) bus_wb ();
  param_datacache_if #(.WORD_SIZE(32)) bus_wt ();

  param_datacache #(.WORD_SIZE(32), .INDEX_BITS(4), .OFFSET_BITS(2), .WRITE_BACK(1'b1))
    dut_wb (.clk(clk), .rst_n(rst_n), .bus(bus_wb));
  param_datacache #(.WORD_SIZE(32), .INDEX_BITS(4), .OFFSET_BITS(2), .WRITE_BACK(1'b0))
    dut_wt (.clk(clk), .rst_n(rst_n), .bus(bus_wt));

  logic [31:0] c_in [2], c_wdata [2], m_rdata [2];
  logic        c_rd [2], c_wr [2], m_ack [2];
  logic [31:0] c_out [2], m_addr [2], m_wdata [2];
  logic        c_over [2], m_req [2], m_we [2];

  assign bus_wb.in = c_in[0];        assign bus_wt.in = c_in[1];
  assign bus_wb.readable = c_rd[0];  assign bus_wt.readable = c_rd[1];
  assign bus_wb.writable = c_wr[0];  assign bus_wt.writable = c_wr[1];
  assign bus_wb.write = c_wdata[0];  assign bus_wt.write = c_wdata[1];
  assign bus_wb.mem_rdata = m_rdata[0]; assign bus_wt.mem_rdata = m_rdata[1];
  assign bus_wb.mem_ack = m_ack[0];  assign bus_wt.mem_ack = m_ack[1];
  assign c_out[0] = bus_wb.out;      assign c_out[1] = bus_wt.out;
  assign c_over[0] = bus_wb.over;    assign c_over[1] = bus_wt.over;
  assign m_req[0] = bus_wb.mem_req;  assign m_req[1] = bus_wt.mem_req;
  assign m_we[0] = bus_wb.mem_we;    assign m_we[1] = bus_wt.mem_we;
  assign m_addr[0] = bus_wb.mem_addr;   assign m_addr[1] = bus_wt.mem_addr;
  assign m_wdata[0] = bus_wb.mem_wdata; assign m_wdata[1] = bus_wt.mem_wdata;

  typedef struct { int k; bit we; logic [31:0] addr; logic [31:0] data; } txn_t;

  int checks = 0, fails = 0, cyc = 0, dly = 3;
  int over_cnt = 0, acc_cnt = 0, req_cyc = 0, over_cyc = 0;
  bit pend = 1'b0;
  int exp_k = 0;
  logic [31:0] exp_out = '0, last_out = '0;
  txn_t exq[$];
  txn_t alog[$];

  // Model state: residency per line, plus the model's own memory copy
  bit          rv [2][16];
  int          rt [2][16];
  bit          rdty [2][16];
  logic [31:0] cl [2][16][4];
  logic [31:0] mm [int];
  logic [31:0] bm [int];   // responder's backing memory

  function automatic logic [31:0] init_word(int a);
    return 32'hA5A50000 | 32'(a);
  endfunction

  function automatic logic [31:0] mget(int k, int a);
    if (mm.exists(k*1000000 + a)) return mm[k*1000000 + a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] bget(int k, int a);
    if (bm.exists(k*1000000 + a)) return bm[k*1000000 + a];
    return init_word(a);
  endfunction

  task automatic chk(bit ok, string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %08h required %08h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(int k, bit we, int a, logic [31:0] d);
    txn_t t;
    t.k = k; t.we = we; t.addr = 32'(a); t.data = d;
    exq.push_back(t);
  endtask

  // Predict the transactions and result of one access. A write wins over a read.
  task automatic plan(int k, int a, bit wr, logic [31:0] d);
    int idx, tg, off, wa;
    bit hit;
    idx = (a >> 2) & 15; tg = a >> 6; off = a & 3;
    hit = rv[k][idx] && rt[k][idx] == tg;
    if (wr && k == 1) begin
      push(k, 1'b1, a, d);
      mm[k*1000000 + a] = d;
      if (hit) cl[k][idx][off] = d;
      exp_out = d;
    end else begin
      if (!hit) begin
        if (k == 0 && rv[k][idx] && rdty[k][idx])
          for (int w = 0; w < 4; w++) begin
            wa = (rt[k][idx] << 6) | (idx << 2) | w;
            push(k, 1'b1, wa, cl[k][idx][w]);
            mm[k*1000000 + wa] = cl[k][idx][w];
          end
        for (int w = 0; w < 4; w++) begin
          wa = (tg << 6) | (idx << 2) | w;
          push(k, 1'b0, wa, '0);
          cl[k][idx][w] = mget(k, wa);
        end
        rv[k][idx] = 1'b1; rt[k][idx] = tg; rdty[k][idx] = 1'b0;
      end
      if (wr) begin
        cl[k][idx][off] = d; rdty[k][idx] = 1'b1; exp_out = d;
      end else begin
        exp_out = cl[k][idx][off];
      end
    end
    exp_k = k;
    pend  = 1'b1;
  endtask

  task automatic reset_model();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++) begin rv[k][i] = 1'b0; rdty[k][i] = 1'b0; end
    exq.delete();
    pend = 1'b0;
  endtask

  task automatic access(int k, int a, bit rd, bit wr, logic [31:0] d, bit glitch, output int lat);
    int n, t0;
    plan(k, a, wr, d);
    alog.delete(); req_cyc = 0; over_cyc = 0; acc_cnt++;
    @(posedge clk); #1;
    c_in[k] = 32'(a); c_rd[k] = rd; c_wr[k] = wr; c_wdata[k] = d; t0 = cyc;
    n = 0;
    while (pend && n < 400) begin
      @(posedge clk); n++;
      if (glitch && n == 5) begin #1; c_wr[k] = 1'b1; c_in[k] = 32'(a + 7); end
      else if (glitch && n == 6) begin #1; c_wr[k] = wr; c_in[k] = 32'(a); end
    end
    chk(!pend, "over_timeout", 32'(n), 32'd400);
    pend = 1'b0;
    #1; c_rd[k] = 1'b0; c_wr[k] = 1'b0;
    chk(exq.size() == 0, "txn_missing", 32'(exq.size()), 32'd0);
    exq.delete();
    lat = over_cyc - t0;
  endtask

  initial forever begin @(posedge clk); cyc++; end

  // Memory responders: ack after dly idle cycles, one cycle wide
  initial forever begin
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin : resp
      static int wt [2] = '{0, 0};
      if (rst_n !== 1'b1) begin
        m_ack[k] = 1'b0; wt[k] = 0;
      end else if (m_ack[k]) begin
        m_ack[k] = 1'b0;
      end else if (m_req[k]) begin
        if (wt[k] >= dly) begin
          wt[k] = 0; m_ack[k] = 1'b1;
          if (m_we[k]) bm[k*1000000 + int'(m_addr[k])] = m_wdata[k];
          else         m_rdata[k] = bget(k, int'(m_addr[k]));
        end else begin
          wt[k]++;
        end
      end
    end
  end

  // Compare process: memory traffic, handshake rules and completions
  initial begin
    logic        prv_req [2], prv_ack [2], prv_we [2];
    logic [31:0] prv_addr [2], prv_wd [2];
    txn_t e, o;
    for (int k = 0; k < 2; k++) begin prv_req[k] = 0; prv_ack[k] = 0; prv_we[k] = 0; prv_addr[k] = 0; prv_wd[k] = 0; end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst_n !== 1'b1) begin
          prv_req[k] = 1'b0; prv_ack[k] = 1'b0;
        end else begin
          if (prv_req[k] && !prv_ack[k]) begin
            chk(m_req[k] == 1'b1, "req_hold", 32'(m_req[k]), 32'd1);
            chk(m_addr[k] == prv_addr[k] && m_we[k] == prv_we[k] && (!m_we[k] || m_wdata[k] == prv_wd[k]),
                "req_stable", m_addr[k], prv_addr[k]);
          end
          if (prv_req[k] && prv_ack[k])
            chk(m_req[k] == 1'b0, "req_gap", 32'(m_req[k]), 32'd0);
          if (m_req[k]) req_cyc++;
          if (m_req[k] && m_ack[k]) begin
            o.k = k; o.we = m_we[k]; o.addr = m_addr[k]; o.data = m_we[k] ? m_wdata[k] : m_rdata[k];
            alog.push_back(o);
            if (exq.size() == 0) chk(1'b0, "txn_unexpected", m_addr[k], 32'd0);
            else begin
              e = exq.pop_front();
              chk(e.k == k && e.we == m_we[k] && e.addr == m_addr[k], "txn_addr", m_addr[k], e.addr);
              if (e.we) chk(m_wdata[k] == e.data, "txn_wdata", m_wdata[k], e.data);
            end
          end
          if (c_over[k]) begin
            over_cnt++;
            chk(pend && exp_k == k, "over_expected", 32'(k), 32'(exp_k));
            if (pend && exp_k == k) begin
              chk(c_out[k] == exp_out, "out_model", c_out[k], exp_out);
              last_out = c_out[k]; over_cyc = cyc; pend = 1'b0;
            end
          end
          prv_req[k] = m_req[k]; prv_ack[k] = m_ack[k]; prv_we[k] = m_we[k];
          prv_addr[k] = m_addr[k]; prv_wd[k] = m_wdata[k];
        end
      end
    end
  end

  initial begin
    int lat, n;
    logic [31:0] o0;
    for (int k = 0; k < 2; k++) begin
      c_in[k] = '0; c_wdata[k] = '0; c_rd[k] = 0; c_wr[k] = 0; m_ack[k] = 0; m_rdata[k] = '0;
    end
    rst_n = 1'b0;
    reset_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk(c_out[k] == 0 && c_over[k] == 0, "rst_out_over", c_out[k], 32'd0);
      chk(m_req[k] == 0 && m_we[k] == 0 && m_addr[k] == 0 && m_wdata[k] == 0, "rst_mem", m_addr[k], 32'd0);
    end
    rst_n = 1'b1;

    // 1: cold read miss, then hit
    access(0, 0, 1, 0, '0, 0, lat);
    chk(last_out == 32'hA5A50000, "t1_out", last_out, 32'hA5A50000);
    chk(alog.size() == 4 && alog[3].addr == 3 && !alog[3].we, "t1_refill", 32'(alog.size()), 32'd4);
    access(0, 0, 1, 0, '0, 0, lat);
    chk(lat == 2, "t1_hit_latency", 32'(lat), 32'd2);
    chk(req_cyc == 0, "t1_no_mem_req", 32'(req_cyc), 32'd0);

    // 2: write hit with both request lines high, then reads
    access(0, 1, 1, 1, 32'b111101, 0, lat);
    chk(last_out == 32'h0000003D, "t2_write_out", last_out, 32'h0000003D);
    chk(req_cyc == 0 && lat == 2, "t2_write_hit", 32'(req_cyc), 32'd0);
    access(0, 1, 1, 0, '0, 0, lat);
    chk(last_out == 32'h0000003D, "t2_read1", last_out, 32'h0000003D);
    access(0, 2, 1, 0, '0, 0, lat);
    chk(last_out == 32'hA5A50002 && req_cyc == 0, "t2_read2", last_out, 32'hA5A50002);

    // 3: conflict miss evicts the dirty line
    access(0, 64, 1, 0, '0, 0, lat);
    chk(last_out == 32'hA5A50040, "t3_out", last_out, 32'hA5A50040);
    chk(alog.size() == 8, "t3_txn_count", 32'(alog.size()), 32'd8);
    chk(alog[1].we && alog[1].addr == 1 && alog[1].data == 32'h3D, "t3_wback_word1", alog[1].data, 32'h3D);
    chk(!alog[4].we && alog[4].addr == 64, "t3_refill_start", alog[4].addr, 32'd64);

    // 4: write-through instance
    access(1, 5, 0, 1, 32'h12345678, 0, lat);
    chk(alog.size() == 1 && alog[0].we && alog[0].addr == 5, "t4_wthru", 32'(alog.size()), 32'd1);
    access(1, 5, 1, 0, '0, 0, lat);
    chk(last_out == 32'h12345678, "t4_read_back", last_out, 32'h12345678);
    chk(alog.size() == 4 && alog[0].addr == 4, "t4_refill", alog[0].addr, 32'd4);
    access(1, 6, 0, 1, 32'hCAFEF00D, 0, lat);
    chk(alog.size() == 1 && alog[0].data == 32'hCAFEF00D, "t4_wthru_hit", alog[0].data, 32'hCAFEF00D);
    access(1, 6, 1, 0, '0, 0, lat);
    chk(last_out == 32'hCAFEF00D && lat == 2, "t4_hit_read", last_out, 32'hCAFEF00D);

    // 5: reset during the second refill word
    plan(0, 0, 1'b0, '0);
    alog.delete();
    @(posedge clk); #1; c_in[0] = '0; c_rd[0] = 1'b1;
    n = 0;
    while (n < 200 && !(alog.size() == 1 && m_req[0])) begin @(negedge clk); #2; n++; end
    chk(n < 200, "t5_second_word_seen", 32'(n), 32'd200);
    rst_n = 1'b0;
    #1;
    chk(m_req[0] == 1'b0 && c_over[0] == 1'b0, "t5_abort", 32'(m_req[0]), 32'd0);
    reset_model();
    c_rd[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    access(0, 0, 1, 0, '0, 0, lat);
    chk(last_out == 32'hA5A50000 && alog.size() == 4, "t5_full_refill", 32'(alog.size()), 32'd4);
    access(0, 1, 1, 0, '0, 0, lat);
    chk(last_out == 32'h0000003D, "t5_written_back", last_out, 32'h0000003D);

    // 6: zero-wait vs long-wait memory, request glitch while busy
    dly = 0;
    access(0, 130, 1, 0, '0, 0, lat);
    o0 = last_out;
    chk(o0 == 32'hA5A50082, "t6_fast", o0, 32'hA5A50082);
    dly = 10;
    access(1, 130, 1, 0, '0, 1, lat);
    chk(last_out == o0, "t6_slow_same", last_out, o0);
    repeat (4) @(posedge clk);
    chk(over_cnt == acc_cnt, "over_count", 32'(over_cnt), 32'(acc_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
